mmio_periph: RTL and testbench

MMIO_PERIPH -- requirements
Module: mmio_periph

---
 rtl/mmio_periph.sv | 152 +++++++++++++++
 tb/tb_mmio_periph.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral: free-running timer with compare/IRQ plus a 4-entry byte TX FIFO.
// Latency: register reads are combinational; writes show up on rd after the next rising edge.
// Backpressure: TX FIFO drains on tx_valid & tx_ready; a push into a full FIFO with no pop drops the byte and sets overflow.
// Optional feature macro: MMIO_PRESCALE_EN (adds CTRL[7:4] timer prescaler).
module mmio_periph (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam logic [2:0] OFF_TIMER  = 3'd0;
    localparam logic [2:0] OFF_CMP    = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_CTRL   = 3'd3;
    localparam logic [2:0] OFF_TXDATA = 3'd4;

    logic [31:0] timer;
    logic [31:0] cmp;
    logic        match;
    logic        overflow;
    logic        en;
    logic        irq_en;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic [2:0]  off;
    logic        wr_timer, wr_cmp, wr_status, wr_ctrl, wr_tx;
    logic        full, empty, pop, push_ok, ovf_set, match_set, tick;
    logic        unused_addr_bits;

    assign off       = a[4:2];
    assign wr_timer  = sel & we & (off == OFF_TIMER);
    assign wr_cmp    = sel & we & (off == OFF_CMP);
    assign wr_status = sel & we & (off == OFF_STATUS);
    assign wr_ctrl   = sel & we & (off == OFF_CTRL);
    assign wr_tx     = sel & we & (off == OFF_TXDATA);

    // Only a[4:2] selects a register; the remaining address bits are ignored.
    assign unused_addr_bits = ^{a[31:5], a[1:0]};

    assign full      = (count == 3'd4);
    assign empty     = (count == 3'd0);
    assign pop       = tx_valid & tx_ready;
    // A push into a full FIFO still lands if the head leaves on the same edge.
    assign push_ok   = wr_tx & (~full | pop);
    assign ovf_set   = wr_tx & full & ~pop;
    assign match_set = en & (timer == cmp);

`ifdef MMIO_PRESCALE_EN
    logic [3:0] psc_p;
    logic [3:0] psc_cnt;

    assign tick = (psc_cnt == psc_p);

    // Prescale field and divider: the divider restarts on a timer load or while disabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc_p   <= 4'd0;
            psc_cnt <= 4'd0;
        end else begin
            if (wr_ctrl) psc_p <= wd[7:4];
            if (wr_timer || !en || tick) psc_cnt <= 4'd0;
            else                         psc_cnt <= psc_cnt + 4'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Timer, compare and control registers; a timer write beats the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer  <= 32'd0;
            cmp    <= 32'hFFFF_FFFF;
            en     <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (wr_timer)         timer <= wd;
            else if (en && tick)  timer <= timer + 32'd1;
            if (wr_cmp)  cmp <= wd;
            if (wr_ctrl) {irq_en, en} <= wd[1:0];
        end
    end

    // Sticky status flags: a set event on the same edge wins over a W1C clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (match_set)                  match <= 1'b1;
            else if (wr_status && wd[0])    match <= 1'b0;
            if (ovf_set)                    overflow <= 1'b1;
            else if (wr_status && wd[6])    overflow <= 1'b0;
        end
    end

    // TX FIFO storage and pointers; reset empties it without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= wd[7:0];
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign tx_valid = ~empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign irq      = match & irq_en;

    // Combinational read mux; the bus is driven to zero when not selected.
    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (off)
                OFF_TIMER:  rd = timer;
                OFF_CMP:    rd = cmp;
                OFF_STATUS: rd = {25'd0, overflow, count, empty, full, match};
`ifdef MMIO_PRESCALE_EN
                OFF_CTRL:   rd = {24'd0, psc_p, 2'b00, irq_en, en};
`else
                OFF_CTRL:   rd = {30'd0, irq_en, en};
`endif
                default:    rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph: stimulus queues expected read/TX values,
// negedge monitor pops and compares whenever the DUT presents a read or a TX handshake.
module tb_mmio_periph;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    exp_t        rd_q[$];
    logic [7:0]  tx_q[$];
    int          n_vec;
    int          n_fail;

    mmio_periph dut (
        .clk      (clk),
        .reset    (reset),
        .sel      (sel),
        .we       (we),
        .a        (a),
        .wd       (wd),
        .rd       (rd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks start just after a rising edge and return just after the next one.
    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        sel = 1'b1; we = 1'b1; a = {27'd0, off, 2'b00}; wd = data;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
    endtask

    task automatic rd_chk(input logic [2:0] off, input logic [31:0] v,
                          input logic i, input string nm);
        exp_t e;
        e.rd = v; e.irq = i; e.name = nm;
        rd_q.push_back(e);
        sel = 1'b1; we = 1'b0; a = {27'd0, off, 2'b00};
        @(posedge clk); #1;
        sel = 1'b0; a = 32'd0;
    endtask

    // Monitor: compares reads, idle bus, and TX handshakes at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] t;
        if (sel && !we) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: rd=%h with no expected value queued", rd);
            end else begin
                e = rd_q.pop_front();
                if (rd !== e.rd || irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL %s: got rd=%h irq=%b, want rd=%h irq=%b",
                             e.name, rd, irq, e.rd, e.irq);
                end
            end
        end
        if (!sel) begin
            n_vec++;
            if (rd !== 32'd0) begin
                n_fail++;
                $display("FAIL rd_idle: got rd=%h, want 00000000", rd);
            end
        end
        if (tx_valid && tx_ready) begin
            n_vec++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tx: tx_data=%h with nothing queued", tx_data);
            end else begin
                t = tx_q.pop_front();
                if (tx_data !== t) begin
                    n_fail++;
                    $display("FAIL tx_pop: got tx_data=%h, want %h", tx_data, t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_t_v;
        n_vec = 0; n_fail = 0;
        reset = 1'b0; sel = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0; tx_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd_chk(3'd1, 32'hFFFF_FFFF, 1'b0, "in_reset_cmp");
        reset = 1'b1;

        // Reset values for every offset.
        rd_chk(3'd0, 32'h0000_0000, 1'b0, "rst_timer");
        rd_chk(3'd1, 32'hFFFF_FFFF, 1'b0, "rst_cmp");
        rd_chk(3'd2, 32'h0000_0004, 1'b0, "rst_status");
        rd_chk(3'd3, 32'h0000_0000, 1'b0, "rst_ctrl");
        for (int i = 4; i < 8; i++) rd_chk(i[2:0], 32'h0, 1'b0, "rst_unmapped");

        // Compare match and interrupt.
        wr(3'd1, 32'd5);
        wr(3'd3, 32'h3);
        wr(3'd0, 32'd0);
        for (int i = 0; i < 6; i++) rd_chk(3'd0, i, 1'b0, "timer_count");
        rd_chk(3'd2, 32'h0000_0005, 1'b1, "match_set");
        wr(3'd2, 32'h1);
        rd_chk(3'd2, 32'h0000_0004, 1'b0, "match_clear");

        // Set event beats a simultaneous W1C clear.
        wr(3'd3, 32'h0);
        wr(3'd0, 32'd20);
        wr(3'd1, 32'd20);
        wr(3'd3, 32'h1);
        wr(3'd2, 32'h1);
        rd_chk(3'd2, 32'h0000_0005, 1'b0, "set_beats_clear");
        wr(3'd3, 32'h0);
        wr(3'd2, 32'h1);
        rd_chk(3'd2, 32'h0000_0004, 1'b0, "clear_when_idle");

        // Timer wraparound.
        wr(3'd3, 32'h1);
        wr(3'd0, 32'hFFFF_FFFE);
        rd_chk(3'd0, 32'hFFFF_FFFE, 1'b0, "wrap_load");
        rd_chk(3'd0, 32'hFFFF_FFFF, 1'b0, "wrap_max");
        rd_chk(3'd0, 32'h0000_0000, 1'b0, "wrap_zero");
        wr(3'd3, 32'h0);

        // Fill FIFO and overflow.
        wr(3'd4, 32'h11); wr(3'd4, 32'h22); wr(3'd4, 32'h33);
        wr(3'd4, 32'h44); wr(3'd4, 32'h55);
        rd_chk(3'd2, 32'h0000_0062, 1'b0, "full_overflow");
        rd_chk(3'd4, 32'h0000_0000, 1'b0, "txdata_reads_zero");

        // Push while full with a pop on the same edge.
        tx_q.push_back(8'h11);
        tx_ready = 1'b1;
        wr(3'd4, 32'h66);
        tx_ready = 1'b0;
        rd_chk(3'd2, 32'h0000_0062, 1'b0, "push_pop_full");
        wr(3'd2, 32'h40);
        rd_chk(3'd2, 32'h0000_0022, 1'b0, "overflow_clear");

        // Drain in order.
        tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        tx_q.push_back(8'h44); tx_q.push_back(8'h66);
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        rd_chk(3'd2, 32'h0000_0004, 1'b0, "drained");

        // Push into empty FIFO while consumer is ready.
        tx_q.push_back(8'h77);
        tx_ready = 1'b1;
        wr(3'd4, 32'h77);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        rd_chk(3'd2, 32'h0000_0004, 1'b0, "empty_push_pop");

        // Prescale field.
        wr(3'd0, 32'd100);
        wr(3'd3, 32'h31);
`ifdef MMIO_PRESCALE_EN
        rd_chk(3'd3, 32'h0000_0031, 1'b0, "ctrl_prescale");
`else
        rd_chk(3'd3, 32'h0000_0001, 1'b0, "ctrl_prescale");
`endif
        for (int i = 1; i <= 8; i++) begin
`ifdef MMIO_PRESCALE_EN
            exp_t_v = 100 + i / 4;
`else
            exp_t_v = 100 + i;
`endif
            rd_chk(3'd0, exp_t_v, 1'b0, "prescale_timer");
        end

        // Asynchronous reset mid-operation discards FIFO contents.
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h99);
        reset = 1'b0;
        rd_chk(3'd2, 32'h0000_0004, 1'b0, "async_reset_status");
        rd_chk(3'd0, 32'h0000_0000, 1'b0, "async_reset_timer");
        rd_chk(3'd3, 32'h0000_0000, 1'b0, "async_reset_ctrl");

        n_vec++;
        if (rd_q.size() != 0 || tx_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d reads and %0d tx bytes pending, want 0 and 0",
                     rd_q.size(), tx_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
